// File: rtl/mesi_snoop_ctrl.sv
// N-cache MESI coherence controller: round-robin arbiter feeding a single-transaction
// snoop FSM that updates per-cache line state and drives memory fill and writeback.
module mesi_snoop_ctrl #(
    parameter int N         = 4,
    parameter int ADDR_W    = 32,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0]        req_write,
    input  logic [N*ADDR_W-1:0] req_addr,
    output logic [N-1:0]        req_done,
    output logic [2*N-1:0]      line_state,
    output logic [N*ADDR_W-1:0] line_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    output logic                busy
);

    localparam int GW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WB_VICT,
        WB_OWN,
        FILL,
        DONE
    } fsm_t;

    fsm_t              fsm;
    logic [1:0]        st_q  [N];
    logic [ADDR_W-1:0] tag_q [N];
    logic [GW-1:0]     ptr;
    logic [GW-1:0]     g_q;
    logic [ADDR_W-1:0] a_q;
    logic              w_q;

    logic [GW-1:0]     gnt_idx;
    logic              gnt_found;
    logic [N-1:0]      other_match;
    logic              other_m;
    logic              other_valid;
    logic              hit;
    logic [1:0]        g_state;
    logic [ADDR_W-1:0] g_tag;

    // Round-robin arbiter: first requester at or after ptr, wrapping.
    always_comb begin : arb
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        g_state     = st_q[g_q];
        g_tag       = tag_q[g_q];
        other_match = '0;
        other_m     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (j != int'(g_q) && st_q[j] != ST_I && tag_q[j] == a_q) begin
                other_match[j] = 1'b1;
                if (st_q[j] == ST_M) begin
                    other_m = 1'b1;
                end
            end
        end
        other_valid = |other_match;
        hit         = (g_state != ST_I) && (g_tag == a_q);
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign line_state[2*i +: 2]         = st_q[i];
        assign line_addr[i*ADDR_W +: ADDR_W] = tag_q[i];
    end

    // Snoop effects on matching others are applied on every transition into FILL,
    // so the fill result can use other_valid to choose between S and E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            ptr       <= '0;
            g_q       <= '0;
            a_q       <= '0;
            w_q       <= 1'b0;
            req_done  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                st_q[i]  <= ST_I;
                tag_q[i] <= '0;
            end
        end else begin
            req_done <= '0;
            case (fsm)
                IDLE: begin
                    if (gnt_found) begin
                        g_q  <= gnt_idx;
                        a_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                        w_q  <= req_write[gnt_idx];
                        busy <= 1'b1;
                        fsm  <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (hit) begin
                        if (w_q) begin
                            if (g_state == ST_S) begin
                                for (int j = 0; j < N; j++) begin
                                    if (other_match[j]) begin
                                        st_q[j] <= ST_I;
                                    end
                                end
                            end
                            st_q[g_q] <= ST_M;
                        end
                        req_done[g_q] <= 1'b1;
                        fsm           <= DONE;
                    end else if (g_state == ST_M) begin
                        mem_write <= 1'b1;
                        mem_addr  <= g_tag;
                        fsm       <= WB_VICT;
                    end else if (other_m) begin
                        mem_write <= 1'b1;
                        mem_addr  <= a_q;
                        fsm       <= WB_OWN;
                    end else begin
                        for (int j = 0; j < N; j++) begin
                            if (other_match[j]) begin
                                st_q[j] <= w_q ? ST_I : ST_S;
                            end
                        end
                        mem_read <= 1'b1;
                        mem_addr <= a_q;
                        fsm      <= FILL;
                    end
                end
                WB_VICT: begin
                    if (mem_ack) begin
                        st_q[g_q] <= ST_I;
                        if (other_m) begin
                            mem_addr <= a_q;
                            fsm      <= WB_OWN;
                        end else begin
                            for (int j = 0; j < N; j++) begin
                                if (other_match[j]) begin
                                    st_q[j] <= w_q ? ST_I : ST_S;
                                end
                            end
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                            mem_addr  <= a_q;
                            fsm       <= FILL;
                        end
                    end
                end
                WB_OWN: begin
                    if (mem_ack) begin
                        for (int j = 0; j < N; j++) begin
                            if (other_match[j]) begin
                                st_q[j] <= w_q ? ST_I : ST_S;
                            end
                        end
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= a_q;
                        fsm       <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_read   <= 1'b0;
                        tag_q[g_q] <= a_q;
                        if (w_q) begin
                            st_q[g_q] <= ST_M;
                        end else if (other_valid) begin
                            st_q[g_q] <= ST_S;
                        end else begin
                            st_q[g_q] <= ST_E;
                        end
                        req_done[g_q] <= 1'b1;
                        fsm           <= DONE;
                    end
                end
                DONE: begin
                    ptr  <= (int'(g_q) == N - 1) ? '0 : g_q + 1'b1;
                    busy <= 1'b0;
                    fsm  <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    if (ASSERT_EN) begin : g_assert
        always @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = i + 1; j < N; j++) begin
                        if (st_q[i] != ST_I && st_q[j] != ST_I && tag_q[i] == tag_q[j]) begin
                            assert (!(st_q[i] == ST_M && st_q[j] == ST_M));
                            assert (!(st_q[i] == ST_S && (st_q[j] == ST_M || st_q[j] == ST_E)));
                            assert (!(st_q[j] == ST_S && (st_q[i] == ST_M || st_q[i] == ST_E)));
                        end
                    end
                end
                assert ($onehot0(req_done));
            end
        end
    end

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Directed self-checking bench for mesi_snoop_ctrl (N=4): fills, sharing, upgrade,
// owner writeback, victim writeback, round-robin order and mid-fill reset.
module tb_mesi_snoop_ctrl;

    localparam int N      = 4;
    localparam int ADDR_W = 32;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_write;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]        req_done;
    logic [2*N-1:0]      line_state;
    logic [N*ADDR_W-1:0] line_addr;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic                busy;

    int errors = 0;
    int checks = 0;

    int ack_lat = 1;
    int ack_cnt = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int both_cnt = 0;
    int done_cnt [N];
    bit                log_w [$];
    logic [ADDR_W-1:0] log_a [$];

    mesi_snoop_ctrl #(.N(N), .ADDR_W(ADDR_W), .ASSERT_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_done   (req_done),
        .line_state (line_state),
        .line_addr  (line_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks the ack_lat-th cycle of each access and logs completed accesses.
    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            if (mem_read && mem_write) both_cnt++;
            if (mem_read) rd_cycles++;
            if (mem_write) wr_cycles++;
            for (int i = 0; i < N; i++) if (req_done[i]) done_cnt[i]++;
            if (mem_read || mem_write) begin
                ack_cnt++;
                if (ack_cnt >= ack_lat) begin
                    mem_ack = 1'b1;
                    ack_cnt = 0;
                    log_w.push_back(mem_write);
                    log_a.push_back(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    function automatic logic [1:0] ls(input int i);
        return line_state[2*i +: 2];
    endfunction

    function automatic logic [ADDR_W-1:0] la(input int i);
        return line_addr[i*ADDR_W +: ADDR_W];
    endfunction

    task automatic clear_mon();
        rd_cycles = 0;
        wr_cycles = 0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        log_w.delete();
        log_a.delete();
    endtask

    // Issues one request and returns the number of rising edges until req_done (-1 on timeout).
    task automatic do_req(input int c, input bit w, input logic [ADDR_W-1:0] a, output int lat);
        lat = -1;
        @(posedge clk); #1;
        req_valid[c] = 1'b1;
        req_write[c] = w;
        req_addr[c*ADDR_W +: ADDR_W] = a;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (req_done[c]) begin
                lat = k;
                break;
            end
        end
        req_valid[c] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (line_state !== 8'h00) begin errors++; $display("FAIL reset line_state: got %h want 00", line_state); end
        checks++; if (line_addr !== '0) begin errors++; $display("FAIL reset line_addr: got %h want 0", line_addr); end
        checks++; if ({mem_read, mem_write, busy} !== 3'b000) begin errors++; $display("FAIL reset mem_read/mem_write/busy: got %b want 000", {mem_read, mem_write, busy}); end
        checks++; if (req_done !== 4'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset req_done/mem_addr: got %h/%h want 0/0", req_done, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b want 0", busy); end
    endtask

    task automatic test_read_fill();
        int lat;
        clear_mon();
        ack_lat = 3;
        do_req(0, 1'b0, 32'h100, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL read_fill latency: got %0d want 5", lat); end
        checks++; if (rd_cycles !== 3 || wr_cycles !== 0) begin errors++; $display("FAIL read_fill mem cycles: got rd=%0d wr=%0d want rd=3 wr=0", rd_cycles, wr_cycles); end
        checks++; if (log_a.size() !== 1 || log_a[0] !== 32'h100 || log_w[0] !== 1'b0) begin errors++; $display("FAIL read_fill mem_addr: got %0d accesses want one read of 100", log_a.size()); end
        checks++; if (ls(0) !== 2'b10) begin errors++; $display("FAIL read_fill state0: got %b want 10", ls(0)); end
        checks++; if (la(0) !== 32'h100) begin errors++; $display("FAIL read_fill line_addr0: got %h want 100", la(0)); end
        checks++; if (done_cnt[0] !== 1) begin errors++; $display("FAIL read_fill done pulses: got %0d want 1", done_cnt[0]); end
    endtask

    task automatic test_shared_read();
        int lat;
        clear_mon();
        ack_lat = 1;
        do_req(1, 1'b0, 32'h100, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL shared_read latency: got %0d want 3", lat); end
        checks++; if (ls(0) !== 2'b01 || ls(1) !== 2'b01) begin errors++; $display("FAIL shared_read states: got s0=%b s1=%b want 01/01", ls(0), ls(1)); end
        checks++; if (wr_cycles !== 0 || log_a.size() !== 1) begin errors++; $display("FAIL shared_read traffic: got wr=%0d acc=%0d want 0/1", wr_cycles, log_a.size()); end
        checks++; if (la(1) !== 32'h100) begin errors++; $display("FAIL shared_read line_addr1: got %h want 100", la(1)); end
    endtask

    task automatic test_upgrade();
        int lat;
        clear_mon();
        do_req(1, 1'b1, 32'h100, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL upgrade latency: got %0d want 2", lat); end
        checks++; if (ls(0) !== 2'b00 || ls(1) !== 2'b11) begin errors++; $display("FAIL upgrade states: got s0=%b s1=%b want 00/11", ls(0), ls(1)); end
        checks++; if (rd_cycles + wr_cycles !== 0) begin errors++; $display("FAIL upgrade traffic: got %0d mem cycles want 0", rd_cycles + wr_cycles); end
        checks++; if (done_cnt[1] !== 1) begin errors++; $display("FAIL upgrade done pulses: got %0d want 1", done_cnt[1]); end
    endtask

    task automatic test_owner_wb();
        int lat;
        clear_mon();
        ack_lat = 2;
        do_req(2, 1'b0, 32'h100, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL owner_wb latency: got %0d want 6", lat); end
        checks++; if (log_a.size() !== 2 || log_w[0] !== 1'b1 || log_a[0] !== 32'h100 || log_w[1] !== 1'b0 || log_a[1] !== 32'h100) begin errors++; $display("FAIL owner_wb sequence: got %0d accesses want write 100 then read 100", log_a.size()); end
        checks++; if (ls(1) !== 2'b01 || ls(2) !== 2'b01) begin errors++; $display("FAIL owner_wb states: got s1=%b s2=%b want 01/01", ls(1), ls(2)); end
    endtask

    task automatic test_victim();
        int lat;
        clear_mon();
        ack_lat = 1;
        do_req(1, 1'b1, 32'h100, lat);
        checks++; if (lat !== 2 || ls(1) !== 2'b11 || ls(2) !== 2'b00) begin errors++; $display("FAIL victim setup: got lat=%0d s1=%b s2=%b want 2/11/00", lat, ls(1), ls(2)); end
        clear_mon();
        do_req(1, 1'b0, 32'h200, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL victim latency: got %0d want 4", lat); end
        checks++; if (log_a.size() !== 2 || log_w[0] !== 1'b1 || log_a[0] !== 32'h100 || log_w[1] !== 1'b0 || log_a[1] !== 32'h200) begin errors++; $display("FAIL victim sequence: got %0d accesses want write 100 then read 200", log_a.size()); end
        checks++; if (ls(1) !== 2'b10 || la(1) !== 32'h200) begin errors++; $display("FAIL victim line1: got %b @%h want 10 @200", ls(1), la(1)); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int got;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        ack_lat = 1;
        do_req(0, 1'b0, 32'h300, lat);
        do_req(2, 1'b0, 32'h400, lat);
        do_req(3, 1'b0, 32'h500, lat);
        checks++; if (line_state !== 8'hAA) begin errors++; $display("FAIL b2b setup states: got %h want aa", line_state); end
        clear_mon();
        @(posedge clk); #1;
        req_write = '0;
        req_addr[0*ADDR_W +: ADDR_W] = 32'h300;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h200;
        req_addr[2*ADDR_W +: ADDR_W] = 32'h400;
        req_addr[3*ADDR_W +: ADDR_W] = 32'h500;
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            got = -1;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (req_done != '0) begin
                    for (int i = 0; i < N; i++) if (req_done[i]) got = i;
                    break;
                end
            end
            checks++; if (got !== exp_order[n]) begin errors++; $display("FAIL b2b grant %0d: got cache %0d want %0d", n, got, exp_order[n]); end
        end
        req_valid = '0;
        @(posedge clk); #1;
        checks++; if (line_state !== 8'hAA || log_a.size() !== 0) begin errors++; $display("FAIL b2b hits: got states %h accesses %0d want aa/0", line_state, log_a.size()); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL mem exclusive: got %0d cycles with both high want 0", both_cnt); end
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        clear_mon();
        ack_lat = 50;
        seen = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h700;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mem_read) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_fill reach: got mem_read=%b want 1", mem_read); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_read !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_fill async drop: got mem_read=%b busy=%b want 0/0", mem_read, busy); end
        checks++; if (line_state !== 8'h00 || line_addr !== '0) begin errors++; $display("FAIL mid_fill lines: got %h want 00", line_state); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || req_done !== 4'h0) begin errors++; $display("FAIL post_reset idle: got busy=%b done=%h want 0/0", busy, req_done); end
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_shared_read();
        test_upgrade();
        test_owner_wb();
        test_victim();
        test_back_to_back();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mesi_snoop_ctrl.md
Name: mesi_snoop_ctrl

Overview:
- Parametrised N-cache MESI coherence controller; successor to the fixed two-cache MESI checker.
- Each cache tracks one line (tag plus 2-bit state). Requests are serialised through a round-robin arbiter and a single-transaction snoop FSM that drives memory fill and writeback.
- Sits between the per-core cache request ports and the memory port; the line-state outputs feed the coherence assertion checker.

Parameters:
- N, 4, number of caches (2..16).
- ADDR_W, 32, line address width.
- ASSERT_EN, 1, enables internal coherence-invariant assertions.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-cache request; held high until matching req_done.
- req_write  in  N  1 = write, 0 = read; sampled only at grant.
- req_addr  in  N*ADDR_W  per-cache address; slice i = [i*ADDR_W +: ADDR_W].
- req_done  out  N  one-cycle completion pulse to the granted cache.
- line_state  out  2*N  per-cache state: I=00, S=01, E=10, M=11.
- line_addr  out  N*ADDR_W  per-cache held tag.
- mem_read  out  1  fill request; level, held until mem_ack.
- mem_write  out  1  writeback request; level, held until mem_ack.
- mem_addr  out  ADDR_W  address for the current mem_read or mem_write.
- mem_ack  in  1  memory completion; ignored when neither mem_read nor mem_write is high.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all line_state=I, line_addr=0, req_done=0, mem_read=0, mem_write=0, mem_addr=0, busy=0, FSM=IDLE, round-robin pointer=0. Asserting reset mid-transaction abandons it immediately; mem_* drop asynchronously.
- FSM states: IDLE, SNOOP, WB_VICT, WB_OWN, FILL, DONE.
- IDLE: if any req_valid, grant g = first requester at or after the round-robin pointer (wrapping). Latch addr A and write W. Go to SNOOP. The pointer becomes g+1 mod N on DONE.
- SNOOP (1 cycle): hit = line_addr[g]==A and state[g]!=I; other = any j!=g with state[j]!=I and line_addr[j]==A.
  - Read hit (S/E/M): no change -> DONE.
  - Write hit M: no change -> DONE.
  - Write hit E: state[g]=M -> DONE.
  - Write hit S (upgrade): all matching others -> I; state[g]=M -> DONE; no memory traffic.
  - Miss with state[g]==M (victim, different tag): -> WB_VICT.
  - Miss, no victim: -> WB_OWN if a matching other is in M, else apply snoop effects -> FILL.
- WB_VICT: mem_write=1, mem_addr=line_addr[g] until mem_ack; then state[g]=I. Next state per the miss rule above (WB_OWN or FILL).
- WB_OWN: mem_write=1, mem_addr=A until mem_ack; then apply snoop effects -> FILL.
- Snoop effects on matching others:
  - Read: M/E -> S; S stays S.
  - Write: all -> I.
- FILL: mem_read=1, mem_addr=A until mem_ack. Then line_addr[g]=A and state[g] = M if W; else S if any matching other is non-I, else E. -> DONE.
- DONE: req_done[g]=1 for exactly this cycle -> IDLE.
- Latency: hit = req_done two cycles after the grant-sample edge. Miss adds, per memory access, 1 cycle plus the mem_ack wait. mem_ack in the same cycle mem_* rises completes that access.
- req_valid dropped mid-transaction: the transaction still completes and req_done still pulses.
- Simultaneous requests: one grant only; the others wait. Pointer rotation guarantees each requester is served within N transactions.
- mem_read and mem_write are never high together.
- Only the granted cache and matching others change state; all other lines hold.
- ASSERT_EN invariants, checked every cycle out of reset, for any two caches holding the same tag:
  - At most one cache in M for that tag.
  - S never coexists with M or E for that tag.
  - Only one req_done bit high at a time.

Test Plan:
- N=4. Cache0 reads 0x100, all I, ack after 3 cycles -> mem_read held 3 cycles, mem_addr=0x100, state0=E, req_done[0] pulses once.
- Cache1 then reads 0x100 -> state0 E->S, state1=S after fill, no mem_write.
- Cache1 writes 0x100 while in S -> no mem traffic, state0=I, state1=M, req_done[1] two cycles after grant.
- Cache2 reads 0x100 while cache1 holds M -> mem_write to 0x100, then mem_read; final state1=S, state2=S.
- Cache1 (M @0x100) reads 0x200 -> victim mem_write 0x100, then mem_read 0x200; state1=E, line_addr1=0x200.
- req_valid=4'b1111 held, all read hits -> grant order 0,1,2,3,0; reset asserted during FILL -> all states I, mem_read=0 at once, busy=0.
